// File: rtl/seq_div8x4.sv
// Sequential unsigned 8-bit / 4-bit restoring divider, one quotient bit per clock.
// Optional early divide-by-zero completion enabled by macro DIV_ZERO_DETECT_EN.
module seq_div8x4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       dz
);

  localparam int unsigned DW = 8;
  localparam int unsigned VW = 4;
  localparam int unsigned RW = VW + 1;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {IDLE, CALC, DZERO} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [DW-1:0] q_reg, q_nxt;
  logic [VW-1:0] d_reg, d_nxt;
  logic [RW-1:0] r_reg, r_nxt;
  logic          busy_nxt, done_nxt, dz_nxt;
  logic [DW-1:0] quot_nxt;
  logic [VW-1:0] rem_nxt;

  logic [RW-1:0] r_sh, r_iter;
  logic [DW-1:0] q_iter;
  logic          ge;
  logic          zero_div;

`ifdef DIV_ZERO_DETECT_EN
  assign zero_div = (divisor == VW'(0));
`else
  assign zero_div = 1'b0;
`endif

  // One restoring step: shift in next dividend bit, subtract divisor if it fits
  assign r_sh   = {r_reg[VW-1:0], q_reg[DW-1]};
  assign ge     = (r_sh >= {1'b0, d_reg});
  assign r_iter = ge ? RW'(r_sh - {1'b0, d_reg}) : r_sh;
  assign q_iter = {q_reg[DW-2:0], ge};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = zero_div ? DZERO : CALC;
      CALC:    if (cnt == CW'(7)) state_nxt = IDLE;
      DZERO:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt  = cnt;
    q_nxt    = q_reg;
    d_nxt    = d_reg;
    r_nxt    = r_reg;
    busy_nxt = busy;
    done_nxt = 1'b0;
    dz_nxt   = dz;
    quot_nxt = quotient;
    rem_nxt  = remainder;
    case (state)
      IDLE: begin
        if (start) begin
          q_nxt    = dividend;
          d_nxt    = divisor;
          r_nxt    = RW'(0);
          cnt_nxt  = CW'(0);
          busy_nxt = 1'b1;
        end
      end
      CALC: begin
        q_nxt   = q_iter;
        r_nxt   = r_iter;
        cnt_nxt = cnt + CW'(1);
        if (cnt == CW'(7)) begin
          quot_nxt = q_iter;
          rem_nxt  = r_iter[VW-1:0];
          done_nxt = 1'b1;
          busy_nxt = 1'b0;
          dz_nxt   = 1'b0;
        end
      end
      DZERO: begin
        // Dividend is still parked in q_reg; emit the natural algorithm result
        quot_nxt = {DW{1'b1}};
        rem_nxt  = q_reg[VW-1:0];
        dz_nxt   = 1'b1;
        done_nxt = 1'b1;
        busy_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= CW'(0);
      q_reg     <= DW'(0);
      d_reg     <= VW'(0);
      r_reg     <= RW'(0);
      busy      <= 1'b0;
      done      <= 1'b0;
      dz        <= 1'b0;
      quotient  <= DW'(0);
      remainder <= VW'(0);
    end else begin
      cnt       <= cnt_nxt;
      q_reg     <= q_nxt;
      d_reg     <= d_nxt;
      r_reg     <= r_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      dz        <= dz_nxt;
      quotient  <= quot_nxt;
      remainder <= rem_nxt;
    end
  end

endmodule

// File: tb/tb_seq_div8x4.sv
// Self-checking bench for seq_div8x4: directed corners plus random operands vs an arithmetic model.
module tb_seq_div8x4;

  logic       clk, rst, start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy, done, dz;
  logic [7:0] quotient;
  logic [3:0] remainder;

  int vectors = 0;
  int errors  = 0;

`ifdef DIV_ZERO_DETECT_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  seq_div8x4 dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .dz(dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain arithmetic, zero divisor gives 0xFF / dividend[3:0]
  function automatic void model(input int a, input int b, output int q, output int r,
                                output int lat, output int z);
    if (b == 0) begin
      q = 255; r = a % 16; lat = DZ_EN ? 1 : 8; z = DZ_EN ? 1 : 0;
    end else begin
      q = a / b; r = a % b; lat = 8; z = 0;
    end
  endfunction

  // Start one division and collect what the DUT produced; no checking here
  task automatic do_div(input int a, input int b, output int q, output int r, output int z,
                        output int lat, output int bc, output bit got, output bit after,
                        output bit overlap);
    dividend = 8'(a); divisor = 4'(b); start = 1'b1;
    tick();
    start = 1'b0;
    got = 1'b0; lat = 0; bc = 0; overlap = 1'b0; after = 1'b0; q = 0; r = 0; z = 0;
    if (busy) bc++;
    for (int i = 1; i <= 20 && !got; i++) begin
      tick();
      if (done && busy) overlap = 1'b1;
      if (done) begin
        got = 1'b1; lat = i; q = int'(quotient); r = int'(remainder); z = int'(dz);
      end else if (busy) bc++;
    end
    tick();
    after = done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = 8'd0; divisor = 4'd0;
    tick(); tick();
    vectors++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (quotient !== 8'd0)  begin errors++; $display("FAIL reset_quot: got %0d expected 0", quotient); end
    vectors++; if (remainder !== 4'd0) begin errors++; $display("FAIL reset_rem: got %0d expected 0", remainder); end
    vectors++; if (dz !== 1'b0)        begin errors++; $display("FAIL reset_dz: got %b expected 0", dz); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int q, r, z, lat, bc; bit got, after, ov;
    do_div(200, 7, q, r, z, lat, bc, got, after, ov);
    vectors++; if (!got)   begin errors++; $display("FAIL basic_timeout: got no done expected done"); end
    vectors++; if (q != 28) begin errors++; $display("FAIL basic_quot: got %0d expected 28", q); end
    vectors++; if (r != 4)  begin errors++; $display("FAIL basic_rem: got %0d expected 4", r); end
    vectors++; if (lat != 8) begin errors++; $display("FAIL basic_latency: got %0d expected 8", lat); end
    vectors++; if (bc != 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 8", bc); end
    vectors++; if (after)   begin errors++; $display("FAIL basic_done_width: got 2+ cycles expected 1"); end
    vectors++; if (ov)      begin errors++; $display("FAIL basic_done_busy_overlap: got overlap expected none"); end
  endtask

  task automatic test_corners();
    int ta[6] = '{255, 9, 255, 0, 165, 200};
    int tb[6] = '{15, 13, 1, 5, 0, 7};
    int tq[6] = '{17, 0, 255, 0, 255, 28};
    int tr[6] = '{0, 9, 0, 0, 5, 4};
    int q, r, z, lat, bc; bit got, after, ov;
    for (int i = 0; i < 6; i++) begin
      int el, ez;
      el = (tb[i] == 0 && DZ_EN) ? 1 : 8;
      ez = (tb[i] == 0 && DZ_EN) ? 1 : 0;
      do_div(ta[i], tb[i], q, r, z, lat, bc, got, after, ov);
      vectors++; if (q != tq[i]) begin errors++; $display("FAIL corner_quot %0d/%0d: got %0d expected %0d", ta[i], tb[i], q, tq[i]); end
      vectors++; if (r != tr[i]) begin errors++; $display("FAIL corner_rem %0d/%0d: got %0d expected %0d", ta[i], tb[i], r, tr[i]); end
      vectors++; if (lat != el)  begin errors++; $display("FAIL corner_latency %0d/%0d: got %0d expected %0d", ta[i], tb[i], lat, el); end
      vectors++; if (z != ez)    begin errors++; $display("FAIL corner_dz %0d/%0d: got %0d expected %0d", ta[i], tb[i], z, ez); end
      vectors++; if (bc != el)   begin errors++; $display("FAIL corner_busy_cycles %0d/%0d: got %0d expected %0d", ta[i], tb[i], bc, el); end
    end
  endtask

  task automatic test_random();
    int q, r, z, lat, bc, eq, er, el, ez; bit got, after, ov;
    for (int i = 0; i < 40; i++) begin
      int a, b;
      a = int'($urandom_range(0, 255));
      b = (i % 8 == 0) ? 0 : int'($urandom_range(0, 15));
      model(a, b, eq, er, el, ez);
      do_div(a, b, q, r, z, lat, bc, got, after, ov);
      vectors++;
      if (!got || q != eq || r != er || lat != el || z != ez || after || ov) begin
        errors++;
        $display("FAIL random %0d/%0d: got q=%0d r=%0d lat=%0d dz=%0d done=%b hold=%b expected q=%0d r=%0d lat=%0d dz=%0d",
                 a, b, q, r, lat, z, got, after, eq, er, el, ez);
      end
    end
  endtask

  task automatic test_start_busy();
    int ndone = 0, lat = 0, q = 0, r = 0;
    dividend = 8'd100; divisor = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done) begin
        ndone++;
        if (ndone == 1) begin lat = i; q = int'(quotient); r = int'(remainder); end
      end
      if (i == 2) begin start = 1'b1; dividend = 8'd50; divisor = 4'd5; end
      else start = 1'b0;
    end
    vectors++; if (ndone != 1) begin errors++; $display("FAIL busy_start_done_count: got %0d expected 1", ndone); end
    vectors++; if (lat != 8)   begin errors++; $display("FAIL busy_start_latency: got %0d expected 8", lat); end
    vectors++; if (q != 33)    begin errors++; $display("FAIL busy_start_quot: got %0d expected 33", q); end
    vectors++; if (r != 1)     begin errors++; $display("FAIL busy_start_rem: got %0d expected 1", r); end
  endtask

  task automatic test_back_to_back();
    bit got = 1'b0;
    int lat = 0;
    dividend = 8'd100; divisor = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 20 && !got; i++) begin
      tick();
      if (done) got = 1'b1;
    end
    vectors++; if (!got) begin errors++; $display("FAIL b2b_first_timeout: got no done expected done"); end
    start = 1'b1; dividend = 8'd77; divisor = 4'd4;
    tick();
    start = 1'b0;
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy=%b expected 1", busy); end
    got = 1'b0;
    for (int i = 1; i <= 20 && !got; i++) begin
      tick();
      if (i == 4) begin
        vectors++;
        if (quotient !== 8'd33) begin errors++; $display("FAIL b2b_quot_hold: got %0d expected 33", quotient); end
      end
      if (done) begin got = 1'b1; lat = i; end
    end
    vectors++; if (lat != 8)           begin errors++; $display("FAIL b2b_latency: got %0d expected 8", lat); end
    vectors++; if (quotient !== 8'd19) begin errors++; $display("FAIL b2b_quot: got %0d expected 19", quotient); end
    vectors++; if (remainder !== 4'd1) begin errors++; $display("FAIL b2b_rem: got %0d expected 1", remainder); end
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    int q, r, z, lat, bc; bit got, after, ov;
    dividend = 8'd200; divisor = 4'd7; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 8'd0 || remainder !== 4'd0 || dz !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got busy=%b done=%b q=%0d r=%0d dz=%b expected all 0",
               busy, done, quotient, remainder, dz);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) ndone++;
    end
    vectors++; if (ndone != 0) begin errors++; $display("FAIL midreset_no_done: got %0d pulses expected 0", ndone); end
    do_div(200, 7, q, r, z, lat, bc, got, after, ov);
    vectors++;
    if (!got || q != 28 || r != 4 || lat != 8) begin
      errors++;
      $display("FAIL midreset_recover: got q=%0d r=%0d lat=%0d expected q=28 r=4 lat=8", q, r, lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/seq_div8x4.md
# seq_div8x4

Sequential unsigned 8-bit by 4-bit restoring divider, the inverse operation of the team's combinational 4x4 array multiplier. It shares the same Tiny Tapeout I/O budget: operands pack into `ui_in` plus `uio_in`, and results return on `uo_out` and `uio_out`. It produces one quotient bit per clock behind a start/busy/done handshake. A wrapper top-level instantiates it and handles pin packing.

## Interface
Parameters:
- None. Widths are fixed: 8-bit dividend, 4-bit divisor, to match pin packing.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: request a division; sampled only when `busy`=0.
- `dividend` in 8: unsigned dividend, latched on an accepted `start`.
- `divisor` in 4: unsigned divisor, latched on an accepted `start`.
- `busy` out 1: high while a division is in progress.
- `done` out 1: single-cycle pulse when results become valid.
- `quotient` out 8: unsigned quotient, held until the next completion.
- `remainder` out 4: unsigned remainder, held until the next completion.
- `dz` out 1: divide-by-zero flag for the last result. Only driven when `DIV_ZERO_DETECT_EN` is defined; otherwise tied 0.

## Operation
- Reset (`rst`=1 at an edge):
  - State goes to IDLE.
  - `busy`, `done`, `quotient`, `remainder` and `dz` are all 0.
  - Internal registers are cleared.
  - Reset has priority over every other event.
- States:
  - IDLE: accepts `start`.
  - CALC: runs iterations, with a 3-bit counter `cnt` counting 0..7.
- IDLE, `start`=1:
  - Latch the dividend into the shift register Q, the divisor into D, and clear the 5-bit partial remainder R.
  - Set `cnt`=0, go to CALC, set `busy`=1.
- CALC, each cycle:
  - R' = {R[3:0], Q[7]}, and Q shifts left by 1.
  - If R' >= {1'b0, D}: R = R' - D and Q[0]=1.
  - Otherwise: R = R' and Q[0]=0.
  - `cnt` increments.
- CALC, iteration with `cnt`=7:
  - Write `quotient`=Q and `remainder`=R[3:0] (final values).
  - Pulse `done`=1, drop `busy`=0, return to IDLE.
- Arithmetic: the remainder is always < divisor for a nonzero divisor, so it fits in 4 bits. The quotient is unconstrained up to 0xFF.
- Divide by zero, natural algorithm result: `quotient`=0xFF, `remainder`=`dividend[3:0]`.
- `start` while `busy`=1: ignored. Operands are not re-latched and the in-flight division is unaffected.
- `start` in the same cycle that `done`=1 (`busy` already 0): accepted; a new division begins.
- `quotient`/`remainder` keep their previous values during CALC and change only on the completing edge.
- `done` is never high while `busy` is high.

## Timing
- `start` accepted at edge N: `busy`=1 after edge N.
- Iterations occur at edges N+1 .. N+8.
- `done`=1 and results are valid after edge N+8. `busy`=0 after edge N+8.
- Latency from accepted start to `done` is 8 cycles. Throughput is one division per 8 cycles, with back-to-back starts allowed.
- `done` is exactly 1 cycle wide.
- Reset in the middle of CALC aborts at that edge. Outputs go to 0 and no `done` pulse is produced.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro `DIV_ZERO_DETECT_EN`, defined:
  - A `start` with `divisor`=0 skips CALC.
  - At the next edge (N+1): `quotient`=0xFF, `remainder`=`dividend[3:0]`, `dz`=1, `done` pulses, `busy`=0.
  - Latency is 1 cycle.
  - `dz` is cleared to 0 on the completion of any nonzero-divisor division.
- Macro not defined:
  - A zero divisor runs the full 8 cycles and yields the same 0xFF / `dividend[3:0]` result.
  - `dz` is constant 0.

## Test plan
- Basic: `dividend`=200, `divisor`=7, `start` pulse -> `done` 8 cycles later with `quotient`=28, `remainder`=4, `busy` high for exactly 8 cycles.
- Corner values:
  - 255/15 -> q=17, r=0.
  - 9/13 -> q=0, r=9.
  - 255/1 -> q=255, r=0.
  - 0/5 -> q=0, r=0.
- Divide by zero, 0xA5/0 -> q=0xFF, r=5.
  - With the macro: `done` after 1 cycle, `dz`=1.
  - Without the macro: `done` after 8 cycles, `dz`=0.
- Start during busy: start 100/3, then pulse `start` with 50/5 at cycle 3 -> single `done` at cycle 8 with q=33, r=1; no second `done`.
- Back-to-back: assert the second `start` (77/4) in the `done` cycle of the first -> second `done` 8 cycles later with q=19, r=1.
- Reset mid-operation: `rst` at cycle 4 of 200/7 -> all outputs 0 at the next edge, no `done` pulse; a subsequent 200/7 completes correctly.
